// File: rtl/periph_dma_if.sv
// Bus bundle for periph_dma: config (slave) port and peripheral-bus initiator (master) port.
interface periph_dma_if;
   logic        i_sel;
   logic        i_we;
   logic        i_re;
   logic [2:0]  i_addr;
   logic [15:0] i_wdata;
   logic [15:0] o_rdata;
   logic        o_rdy;

   logic [15:0] o_m_addr;
   logic        o_m_sel;
   logic        o_m_we;
   logic        o_m_re;
   logic [15:0] o_m_wdata;
   logic [15:0] i_m_rdata;
   logic        i_m_rdy;

   modport slave (
      input  i_sel, i_we, i_re, i_addr, i_wdata,
      output o_rdata, o_rdy
   );

   modport master (
      output o_m_addr, o_m_sel, o_m_we, o_m_re, o_m_wdata,
      input  i_m_rdata, i_m_rdy
   );
endinterface

// File: rtl/periph_dma.sv
// Peripheral-bus DMA engine: register-programmed 16-bit word copier with
// wait-state handshake, per-beat timeout, software abort and level interrupt.
module periph_dma #(
   parameter int unsigned TIMEOUT_CYC = 255,
   parameter int unsigned ADDR_INC    = 2
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   periph_dma_if.slave  s_bus,
   periph_dma_if.master m_bus,
   output logic         o_int_req,
   output logic         o_busy
);
   typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, FIN = 2'd3} state_t;

   localparam logic [15:0] INC      = 16'(ADDR_INC);
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

   state_t      state_q, state_d;
   logic [15:0] src_q, src_d, dst_q, dst_d, cnt_q, cnt_d;
   logic [15:0] hold_q, hold_d, tcnt_q, tcnt_d;
   logic        src_inc_q, src_inc_d, dst_inc_q, dst_inc_d, int_en_q, int_en_d;
   logic        done_q, done_d, err_q, err_d, tmo_q, tmo_d, int_q;
   logic        busy, wr_en, ctrl_wr, stat_wr, start, abort, beat_ok, beat_tmo;

   assign busy     = (state_q == RD) || (state_q == WR);
   assign wr_en    = s_bus.i_sel && s_bus.i_we;
   assign ctrl_wr  = wr_en && (s_bus.i_addr == 3'd3);
   assign stat_wr  = wr_en && (s_bus.i_addr == 3'd4);
   assign start    = ctrl_wr && s_bus.i_wdata[0] && (state_q == IDLE);
   assign abort    = ctrl_wr && s_bus.i_wdata[4] && busy;
   // Abort takes priority over a beat completing or timing out on the same edge.
   assign beat_ok  = busy && m_bus.i_m_rdy && !abort;
   assign beat_tmo = busy && !m_bus.i_m_rdy && !abort && (tcnt_q == TMO_LAST);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = (cnt_q == 16'd0) ? FIN : RD;
         RD:      if (abort || beat_tmo) state_d = IDLE;
                  else if (beat_ok) state_d = WR;
         WR:      if (abort || beat_tmo) state_d = IDLE;
                  else if (beat_ok) state_d = (cnt_q == 16'd1) ? FIN : RD;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      m_bus.o_m_sel   = 1'b0;
      m_bus.o_m_re    = 1'b0;
      m_bus.o_m_we    = 1'b0;
      m_bus.o_m_addr  = 16'h0000;
      m_bus.o_m_wdata = 16'h0000;
      o_busy          = busy;
      case (state_q)
         RD: begin
            m_bus.o_m_sel  = 1'b1;
            m_bus.o_m_re   = 1'b1;
            m_bus.o_m_addr = src_q;
         end
         WR: begin
            m_bus.o_m_sel   = 1'b1;
            m_bus.o_m_we    = 1'b1;
            m_bus.o_m_addr  = dst_q;
            m_bus.o_m_wdata = hold_q;
         end
         default: ;
      endcase
   end

   always_comb begin
      src_d     = src_q;
      dst_d     = dst_q;
      cnt_d     = cnt_q;
      hold_d    = hold_q;
      src_inc_d = src_inc_q;
      dst_inc_d = dst_inc_q;
      int_en_d  = int_en_q;
      done_d    = done_q;
      err_d     = err_q;
      tmo_d     = tmo_q;
      tcnt_d    = 16'd0;
      if (wr_en && !busy) begin
         case (s_bus.i_addr)
            3'd0:    src_d = s_bus.i_wdata;
            3'd1:    dst_d = s_bus.i_wdata;
            3'd2:    cnt_d = s_bus.i_wdata;
            default: ;
         endcase
      end
      if (ctrl_wr) begin
         src_inc_d = s_bus.i_wdata[1];
         dst_inc_d = s_bus.i_wdata[2];
         int_en_d  = s_bus.i_wdata[3];
      end
      if (stat_wr) begin
         if (s_bus.i_wdata[1]) done_d = 1'b0;
         if (s_bus.i_wdata[2]) err_d  = 1'b0;
         if (s_bus.i_wdata[3]) tmo_d  = 1'b0;
      end
      if (start) begin
         done_d = 1'b0;
         err_d  = 1'b0;
         tmo_d  = 1'b0;
      end
      if (busy && !m_bus.i_m_rdy) tcnt_d = tcnt_q + 16'd1;
      if (beat_ok && (state_q == RD)) hold_d = m_bus.i_m_rdata;
      if (beat_ok && (state_q == WR)) begin
         cnt_d = cnt_q - 16'd1;
         if (src_inc_q) src_d = src_q + INC;
         if (dst_inc_q) dst_d = dst_q + INC;
      end
      // Hardware sets come last so they win over a same-cycle W1C.
      if (beat_tmo) begin
         err_d = 1'b1;
         tmo_d = 1'b1;
      end
      if (abort) err_d = 1'b1;
      if (state_q == FIN) done_d = 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         src_q     <= 16'h0000;
         dst_q     <= 16'h0000;
         cnt_q     <= 16'h0000;
         hold_q    <= 16'h0000;
         tcnt_q    <= 16'h0000;
         src_inc_q <= 1'b0;
         dst_inc_q <= 1'b0;
         int_en_q  <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         tmo_q     <= 1'b0;
         int_q     <= 1'b0;
      end else begin
         src_q     <= src_d;
         dst_q     <= dst_d;
         cnt_q     <= cnt_d;
         hold_q    <= hold_d;
         tcnt_q    <= tcnt_d;
         src_inc_q <= src_inc_d;
         dst_inc_q <= dst_inc_d;
         int_en_q  <= int_en_d;
         done_q    <= done_d;
         err_q     <= err_d;
         tmo_q     <= tmo_d;
         int_q     <= int_en_d & (done_d | err_d);
      end
   end

   assign o_int_req   = int_q;
   assign s_bus.o_rdy = 1'b1;

   always_comb begin
      s_bus.o_rdata = 16'h0000;
      if (s_bus.i_sel && s_bus.i_re) begin
         case (s_bus.i_addr)
            3'd0:    s_bus.o_rdata = src_q;
            3'd1:    s_bus.o_rdata = dst_q;
            3'd2:    s_bus.o_rdata = cnt_q;
            3'd3:    s_bus.o_rdata = {12'h000, int_en_q, dst_inc_q, src_inc_q, 1'b0};
            3'd4:    s_bus.o_rdata = {12'h000, tmo_q, err_q, done_q, busy};
            default: s_bus.o_rdata = 16'h0000;
         endcase
      end
   end
endmodule
